// File: rtl/ckpt_map_table.sv
// Register-rename map table with per-branch checkpoints.
// Renames up to WAYS destinations per cycle with intra-group bypass, tracks
// ready bits from CDB broadcasts, and keeps a full map+ready snapshot per
// in-flight branch so a mispredict restores in a single cycle.
module ckpt_map_table #(
   parameter int unsigned AR_NUM   = 32,
   parameter int unsigned PR_W     = 6,
   parameter int unsigned WAYS     = 3,
   parameter int unsigned CDB_WAYS = 3,
   parameter int unsigned CKPT     = 4,
   localparam int unsigned AR_W    = $clog2(AR_NUM),
   localparam int unsigned CK_W    = $clog2(CKPT)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [WAYS-1:0]          i_new_valid,
   input  logic [WAYS*AR_W-1:0]     i_new_ar,
   input  logic [WAYS*PR_W-1:0]     i_new_pr,
   input  logic [WAYS*AR_W-1:0]     i_src1_ar,
   input  logic [WAYS*AR_W-1:0]     i_src2_ar,
   output logic [WAYS*PR_W-1:0]     o_src1_tag,
   output logic [WAYS*PR_W-1:0]     o_src2_tag,
   output logic [WAYS-1:0]          o_src1_ready,
   output logic [WAYS-1:0]          o_src2_ready,
   output logic [WAYS*PR_W-1:0]     o_told_out,
   input  logic [WAYS-1:0]          i_ckpt_req,
   output logic [WAYS*CK_W-1:0]     o_ckpt_id_out,
   output logic [CK_W:0]            o_ckpt_free_cnt,
   output logic                     o_ckpt_overflow,
   input  logic [CDB_WAYS-1:0]      i_cdb_valid,
   input  logic [CDB_WAYS*PR_W-1:0] i_cdb_tag,
   input  logic                     i_br_valid,
   input  logic [CK_W-1:0]          i_br_id,
   input  logic                     i_br_mispredict,
   input  logic                     i_full_recover,
   input  logic [AR_NUM*PR_W-1:0]   i_arch_map
);

   // Live map state
   logic [PR_W-1:0]   r_map      [AR_NUM];
   logic [AR_NUM-1:0] r_ready;
   // Checkpoint ring
   logic [CKPT-1:0]   r_ck_valid;
   logic [PR_W-1:0]   r_ck_map   [CKPT][AR_NUM];
   logic [AR_NUM-1:0] r_ck_ready [CKPT];
   logic [CK_W-1:0]   r_head;
   logic [CK_W-1:0]   r_tail;
   logic [CK_W:0]     r_count;
   logic [CK_W:0]     r_free_cnt;
   logic              r_overflow;

   // Rename network
   logic [PR_W-1:0]   w_map      [AR_NUM];
   logic [AR_NUM-1:0] w_rdy;
   logic [PR_W-1:0]   w_snap_map [WAYS][AR_NUM];
   logic [AR_NUM-1:0] w_snap_rdy [WAYS];
   logic [AR_W-1:0]   w_a1;
   logic [AR_W-1:0]   w_a2;
   logic [AR_W-1:0]   w_nar;
   // Checkpoint allocation / control
   logic [AR_NUM-1:0] w_ck_rdy   [CKPT];
   logic [WAYS-1:0]   w_alloc;
   logic              w_drop;
   logic [CK_W:0]     w_free;
   logic [CK_W:0]     w_nalloc;
   int unsigned       w_k;
   logic              w_br_ok;
   logic              w_mp;
   logic              w_adv;
   logic [CK_W-1:0]   w_mp_off;
   logic [CKPT-1:0]   w_valid_nxt;
   logic [CK_W-1:0]   w_head_nxt;
   logic [CK_W-1:0]   w_tail_nxt;
   logic [CK_W:0]     w_count_nxt;

   // True when any valid CDB way broadcasts tag
   function automatic logic f_hit(input logic [PR_W-1:0]          tag,
                                  input logic [CDB_WAYS-1:0]      vld,
                                  input logic [CDB_WAYS*PR_W-1:0] tags);
      logic h;
      h = 1'b0;
      for (int c = 0; c < int'(CDB_WAYS); c++) begin
         if (vld[c] && (tags[c*PR_W +: PR_W] == tag)) h = 1'b1;
      end
      return h;
   endfunction

   // Apply CDB, then walk the group oldest-first: lookup, record told, rename, snapshot
   always_comb begin
      w_map        = r_map;
      w_rdy        = '0;
      o_src1_tag   = '0;
      o_src2_tag   = '0;
      o_src1_ready = '0;
      o_src2_ready = '0;
      o_told_out   = '0;
      w_a1         = '0;
      w_a2         = '0;
      w_nar        = '0;
      for (int r = 0; r < int'(AR_NUM); r++) begin
         w_rdy[r] = r_ready[r] | f_hit(r_map[r], i_cdb_valid, i_cdb_tag);
      end
      for (int i = 0; i < int'(WAYS); i++) begin
         w_a1  = i_src1_ar[i*AR_W +: AR_W];
         w_a2  = i_src2_ar[i*AR_W +: AR_W];
         w_nar = i_new_ar[i*AR_W +: AR_W];
         o_src1_tag[i*PR_W +: PR_W] = w_map[w_a1];
         o_src1_ready[i]            = w_rdy[w_a1];
         o_src2_tag[i*PR_W +: PR_W] = w_map[w_a2];
         o_src2_ready[i]            = w_rdy[w_a2];
         o_told_out[i*PR_W +: PR_W] = w_map[w_nar];
         if (i_new_valid[i] && (w_nar != '0)) begin
            w_map[w_nar] = i_new_pr[i*PR_W +: PR_W];
            w_rdy[w_nar] = 1'b0;
         end
         w_snap_map[i] = w_map;
         w_snap_rdy[i] = w_rdy;
      end
   end

   // Hand out checkpoint ids in way order; requests past the free space are dropped
   always_comb begin
      o_ckpt_id_out = '0;
      w_alloc       = '0;
      w_drop        = 1'b0;
      w_nalloc      = '0;
      w_k           = 0;
      w_free        = (CK_W+1)'(CKPT) - r_count;
      for (int i = 0; i < int'(WAYS); i++) begin
         if (i_ckpt_req[i]) begin
            o_ckpt_id_out[i*CK_W +: CK_W] = r_tail + CK_W'(w_k);
            if (w_k < 32'(w_free)) begin
               w_alloc[i] = 1'b1;
               w_nalloc   = w_nalloc + 1'b1;
            end else begin
               w_drop = 1'b1;
            end
            w_k = w_k + 1;
         end
      end
   end

   // Ring pointer / valid-bit next state and CDB refresh of stored snapshots
   always_comb begin
      for (int j = 0; j < int'(CKPT); j++) begin
         for (int r = 0; r < int'(AR_NUM); r++) begin
            w_ck_rdy[j][r] = r_ck_ready[j][r] | f_hit(r_ck_map[j][r], i_cdb_valid, i_cdb_tag);
         end
      end
      w_br_ok     = i_br_valid && r_ck_valid[i_br_id];
      w_mp        = w_br_ok && i_br_mispredict && !i_full_recover;
      w_adv       = (r_count != '0) && !r_ck_valid[r_head];
      w_mp_off    = i_br_id - r_head;
      w_valid_nxt = r_ck_valid;
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      w_count_nxt = r_count;
      if (i_full_recover) begin
         w_valid_nxt = '0;
         w_head_nxt  = '0;
         w_tail_nxt  = '0;
         w_count_nxt = '0;
      end else if (w_mp) begin
         // br_id and everything younger (offset from head >= br_id's) is squashed
         for (int j = 0; j < int'(CKPT); j++) begin
            if (CK_W'(CK_W'(j) - r_head) >= w_mp_off) w_valid_nxt[j] = 1'b0;
         end
         w_tail_nxt  = i_br_id;
         w_count_nxt = {1'b0, w_mp_off};
      end else begin
         if (w_br_ok) w_valid_nxt[i_br_id] = 1'b0;
         for (int i = 0; i < int'(WAYS); i++) begin
            if (w_alloc[i]) w_valid_nxt[o_ckpt_id_out[i*CK_W +: CK_W]] = 1'b1;
         end
         w_head_nxt  = r_head + CK_W'(w_adv);
         w_tail_nxt  = r_tail + CK_W'(w_nalloc);
         w_count_nxt = r_count - (CK_W+1)'(w_adv) + w_nalloc;
      end
   end

   // Live map, ring control and sticky overflow
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < int'(AR_NUM); r++) r_map[r] <= PR_W'(r);
         r_ready    <= '1;
         r_ck_valid <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_free_cnt <= (CK_W+1)'(CKPT);
         r_overflow <= 1'b0;
      end else begin
         if (i_full_recover) begin
            for (int r = 0; r < int'(AR_NUM); r++) r_map[r] <= i_arch_map[r*PR_W +: PR_W];
            r_ready <= '1;
         end else if (w_mp) begin
            r_map   <= r_ck_map[i_br_id];
            r_ready <= w_ck_rdy[i_br_id];
         end else begin
            r_map      <= w_map;
            r_ready    <= w_rdy;
            r_overflow <= r_overflow | w_drop;
         end
         r_ck_valid <= w_valid_nxt;
         r_head     <= w_head_nxt;
         r_tail     <= w_tail_nxt;
         r_count    <= w_count_nxt;
         r_free_cnt <= (CK_W+1)'(CKPT) - w_count_nxt;
      end
   end

   // Snapshot storage; contents only matter while the matching valid bit is set
   always_ff @(posedge i_clk) begin
      for (int j = 0; j < int'(CKPT); j++) r_ck_ready[j] <= w_ck_rdy[j];
      if (!i_full_recover && !w_mp) begin
         for (int i = 0; i < int'(WAYS); i++) begin
            if (w_alloc[i]) begin
               r_ck_map[o_ckpt_id_out[i*CK_W +: CK_W]]   <= w_snap_map[i];
               r_ck_ready[o_ckpt_id_out[i*CK_W +: CK_W]] <= w_snap_rdy[i];
            end
         end
      end
   end

   assign o_ckpt_free_cnt = r_free_cnt;
   assign o_ckpt_overflow = r_overflow;

endmodule
